data_mem_responder: RTL and testbench

Multi-cycle data-memory responder: the target end of the Rd/Wr/Done/Stall request interface driven by the processor's memory stage. It accepts one word request at a time, holds Stall while the access is in flight, and pulses Done after a fixed, parameterized latency with read data. It drops in wherever the pipeline needs a stalling memory model without a cache: bring-up, stall-path verification, and the instruction side.

---
 rtl/data_mem_pkg.sv | 6 +
 rtl/word_mem_array.sv | 18 +
 rtl/data_mem_responder.sv | 86 ++++++++
 tb/tb_data_mem_responder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared types and constants for the stalling data-memory responder
package data_mem_pkg;
  localparam int WORD_W = 16;
  localparam int DEF_LATENCY = 4;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/word_mem_array.sv
// word_mem_array: word array with async read and a single sync write port, contents not reset
module word_mem_array
  import data_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int W = WORD_W
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [W-1:0]          wdata_i,
  output logic [W-1:0]          rdata_o
);
  logic [W-1:0] mem_q [2**DEPTH_LOG2];
  // Write lands at the end of the cycle we_i is high
  always_ff @(posedge clk) if (we_i) mem_q[addr_i] <= wdata_i;
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: one-at-a-time word access with fixed latency, Stall while in flight, Done pulse
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int ADDR_WORDS_LOG2 = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] Addr,
  input  logic [WORD_W-1:0] DataIn,
  input  logic              Rd,
  input  logic              Wr,
  input  logic              createdump,
  output logic [WORD_W-1:0] DataOut,
  output logic              Done,
  output logic              Stall,
  output logic              CacheHit,
  output logic              err
);
  localparam int CW = $clog2(LATENCY + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_WORDS_LOG2-1:0] idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d, rdata;
  logic rd_q, rd_d, halted_q, halted_d;
  logic idle_open, req, bad, unused_addr_hi;
  assign unused_addr_hi = ^Addr[WORD_W-1:ADDR_WORDS_LOG2+1];
  assign idle_open = state_q == IDLE && !halted_q;
  assign req = idle_open && (Rd ^ Wr) && !Addr[0];
  assign bad = idle_open && (Rd | Wr) && ((Rd & Wr) | Addr[0]);
  assign Done = state_q == DONE;
  assign Stall = req || state_q == BUSY;
  assign err = bad;
  assign DataOut = (Done && rd_q) ? rdata : '0;
  assign CacheHit = 1'b0;
  word_mem_array #(.DEPTH_LOG2(ADDR_WORDS_LOG2), .W(WORD_W)) u_mem (
    .clk(clk),
    .we_i(Done && !rd_q),
    .addr_i(idx_q),
    .wdata_i(wdata_q),
    .rdata_o(rdata)
  );
  // State, counter and request latches; reset aborts any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      wdata_q <= '0;
      rd_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      wdata_q <= wdata_d;
      rd_q <= rd_d;
      halted_q <= halted_d;
    end
  end
  // Next state: accept in IDLE, count down in BUSY, complete in DONE; halt only gates new requests
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    wdata_d = wdata_q;
    rd_d = rd_q;
    halted_d = halted_q | createdump;
    case (state_q)
      IDLE: if (req) begin
        state_d = BUSY;
        cnt_d = CW'(LATENCY - 1);
        idx_d = Addr[ADDR_WORDS_LOG2:1];
        wdata_d = DataIn;
        rd_d = Rd;
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(cnt_q != '0);
        state_d = cnt_q == CW'(1) ? DONE : BUSY;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed stimulus checked against a transaction-level model plus literal expectations
module tb_data_mem_responder;
  localparam int LAT = 4;
  logic clk = 1'b0, rst = 1'b1, Rd = 1'b0, Wr = 1'b0, createdump = 1'b0;
  logic [15:0] Addr = 16'h0, DataIn = 16'h0;
  logic [15:0] DataOut;
  logic Done, Stall, CacheHit, err;
  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.LATENCY(LAT), .ADDR_WORDS_LOG2(10)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .createdump(createdump), .DataOut(DataOut), .Done(Done), .Stall(Stall),
    .CacheHit(CacheHit), .err(err)
  );

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: 'since' counts cycles after acceptance; Done is due when it reaches LAT
  int since = 0;
  bit halted = 0, p_rd = 0;
  logic [9:0] p_idx = '0;
  logic [15:0] p_data = '0;
  logic [15:0] mem_m [int];

  always @(negedge clk) begin
    bit legal, bad, e_done, e_stall;
    logic [15:0] e_do;
    if (rst) begin
      since = 0;
      halted = 0;
    end
    legal = !halted && since == 0 && (Rd ^ Wr) && !Addr[0];
    bad = !halted && since == 0 && (Rd | Wr) && ((Rd && Wr) || Addr[0]);
    e_done = since == LAT;
    e_stall = legal || (since > 0 && since < LAT);
    e_do = (e_done && p_rd) ? mem_m[int'(p_idx)] : 16'h0;
    chk("m_done", 16'(Done), 16'(e_done));
    chk("m_stall", 16'(Stall), 16'(e_stall));
    chk("m_err", 16'(err), 16'(bad));
    chk("m_dout", DataOut, e_do);
    chk("m_hit", 16'(CacheHit), 16'h0);
    if (e_done && !p_rd) mem_m[int'(p_idx)] = p_data;
    if (createdump && since == 0) halted = 1;
    if (legal) begin
      p_rd = Rd;
      p_idx = Addr[10:1];
      p_data = DataIn;
    end
    since = e_done ? 0 : since > 0 ? since + 1 : legal ? 1 : 0;
  end

  task automatic drive(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    Rd = rd;
    Wr = wr;
    Addr = a;
    DataIn = d;
  endtask

  task automatic txn(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                     input logic [15:0] exp);
    drive(rd, wr, a, d);
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      chk("t_stall", 16'(Stall), 16'(k < LAT));
      chk("t_done", 16'(Done), 16'(k == LAT));
      chk("t_err", 16'(err), 16'h0);
      if (k == LAT) chk("t_dout", DataOut, exp);
    end
  endtask

  initial begin
    int nd;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("r_done", 16'(Done), 16'h0);
    chk("r_stall", 16'(Stall), 16'h0);
    chk("r_err", 16'(err), 16'h0);
    chk("r_dout", DataOut, 16'h0);
    chk("r_hit", 16'(CacheHit), 16'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    txn(0, 1, 16'h0010, 16'hBEEF, 16'h0);
    txn(1, 0, 16'h0010, 16'h0, 16'hBEEF);
    drive(1, 0, 16'h0011, 16'h0);
    @(negedge clk);
    chk("mis_err", 16'(err), 16'h1);
    chk("mis_stall", 16'(Stall), 16'h0);
    chk("mis_done", 16'(Done), 16'h0);
    drive(0, 0, 16'h0, 16'h0);
    repeat (LAT + 1) begin
      @(negedge clk);
      chk("mis_nodone", 16'(Done), 16'h0);
    end
    drive(1, 1, 16'h0010, 16'h0000);
    @(negedge clk);
    chk("both_err", 16'(err), 16'h1);
    chk("both_stall", 16'(Stall), 16'h0);
    txn(1, 0, 16'h0010, 16'h0, 16'hBEEF);
    txn(0, 1, 16'h0020, 16'h5555, 16'h0);
    drive(0, 1, 16'h0020, 16'h1234);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    Wr = 1'b0;
    @(negedge clk);
    chk("abort_done", 16'(Done), 16'h0);
    chk("abort_stall", 16'(Stall), 16'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (LAT) begin
      @(negedge clk);
      chk("abort_nodone", 16'(Done), 16'h0);
    end
    txn(1, 0, 16'h0020, 16'h0, 16'h5555);
    txn(0, 1, 16'h0030, 16'hA5A5, 16'h0);
    txn(1, 0, 16'h0030, 16'h0, 16'hA5A5);
    drive(1, 0, 16'h0010, 16'h0);
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (Done) nd++;
      chk("held_done", 16'(Done), 16'(k == 4 || k == 9));
      chk("held_stall", 16'(Stall), 16'(!(k == 4 || k == 9)));
    end
    chk("held_count", 16'(nd), 16'd2);
    drive(0, 0, 16'h0, 16'h0);
    createdump = 1'b1;
    @(negedge clk);
    drive(1, 0, 16'h0010, 16'h0);
    createdump = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("halt_stall", 16'(Stall), 16'h0);
      chk("halt_done", 16'(Done), 16'h0);
      chk("halt_err", 16'(err), 16'h0);
    end
    drive(1, 0, 16'h0011, 16'h0);
    repeat (3) begin
      @(negedge clk);
      chk("halt_mis_err", 16'(err), 16'h0);
    end
    drive(0, 0, 16'h0, 16'h0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    txn(1, 0, 16'h0010, 16'h0, 16'hBEEF);
    drive(0, 0, 16'h0, 16'h0);
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
